// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO with
// first-word-fall-through output, one-cycle-early stall, and flush on mispredict.
module fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_pc,
   input  logic [31:0]       fetch_instr,
   input  logic              fetch_guesses_branch,
   input  logic [ADDR_W-1:0] fetch_prediction,
   input  logic              flush,
   input  logic              decode_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_instr,
   output logic              out_guesses_branch,
   output logic [ADDR_W-1:0] out_prediction,
   output logic              fetch_stall,
   output logic [PTR_W:0]    count,
   output logic              overflow
);

   localparam int ENTRY_W = 2 * ADDR_W + 33;
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0]   head_reg, tail_reg;
   logic [PTR_W:0]     count_reg, count_next;
   logic               overflow_reg;
   logic               push, pop, drop;
   logic [ENTRY_W-1:0] entry_q [DEPTH];
   logic [ENTRY_W-1:0] head_entry;

   assign pop  = (count_reg != '0) && decode_ready && !flush;
   assign push = fetch_valid && !flush && ((count_reg < FULL) || pop);
   assign drop = fetch_valid && !flush && (count_reg == FULL) && !pop;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         // Flush rewinds pointers only; stale storage is harmless since count is 0.
         if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
         end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            count_reg <= count_next;
         end
         if (drop) overflow_reg <= 1'b1;
      end
   end

   // Storage is reset so out_* never carry X, even when the queue is empty.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [ENTRY_W-1:0] entry_reg;
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)
               entry_reg <= '0;
            else if (push && (tail_reg == PTR_W'(gi)))
               entry_reg <= {fetch_pc, fetch_instr, fetch_guesses_branch, fetch_prediction};
         end
         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   assign head_entry = entry_q[head_reg];

   assign out_valid          = (count_reg != '0);
   assign out_pc             = head_entry[ENTRY_W-1 -: ADDR_W];
   assign out_instr          = head_entry[ADDR_W+32 -: 32];
   assign out_guesses_branch = head_entry[ADDR_W];
   assign out_prediction     = head_entry[ADDR_W-1:0];
   assign fetch_stall        = (count_reg >= FULL - 1'b1);
   assign count              = count_reg;
   assign overflow           = overflow_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ordering, full/overflow, wrap, flush, async reset.
module tb_fetch_queue;
   localparam int DEPTH = 8;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          fetch_valid;
   logic [AW-1:0] fetch_pc;
   logic [31:0]   fetch_instr;
   logic          fetch_guesses_branch;
   logic [AW-1:0] fetch_prediction;
   logic          flush;
   logic          decode_ready;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [31:0]   out_instr;
   logic          out_guesses_branch;
   logic [AW-1:0] out_prediction;
   logic          fetch_stall;
   logic [3:0]    count;
   logic          overflow;

   int checks = 0;
   int failures = 0;
   logic [AW-1:0] model_q[$];

   fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .n_rst(n_rst),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_guesses_branch(fetch_guesses_branch), .fetch_prediction(fetch_prediction),
      .flush(flush), .decode_ready(decode_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_guesses_branch(out_guesses_branch), .out_prediction(out_prediction),
      .fetch_stall(fetch_stall), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [AW-1:0] pc, input logic rdy, input logic fl);
      fetch_valid          = v;
      fetch_pc             = pc;
      fetch_instr          = pc ^ 32'hA5A5_0000;
      fetch_guesses_branch = pc[2];
      fetch_prediction     = pc + 32'h40;
      decode_ready         = rdy;
      flush                = fl;
      @(posedge clk);
      #1;
      fetch_valid  = 1'b0;
      decode_ready = 1'b0;
      flush        = 1'b0;
      $display("step v=%0b pc=0x%0h rdy=%0b fl=%0b -> count=%0d out_valid=%0b out_pc=0x%0h stall=%0b ovf=%0b",
               v, pc, rdy, fl, count, out_valid, out_pc, fetch_stall, overflow);
   endtask

   initial begin
      logic v, r;
      int pushed, k;
      logic [AW-1:0] exp_pc;

      n_rst = 1'b0;
      fetch_valid = 0; fetch_pc = 0; fetch_instr = 0; fetch_guesses_branch = 0;
      fetch_prediction = 0; flush = 0; decode_ready = 0;
      #12;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_pc", 64'(out_pc), 64'd0);
      chk("reset_instr", 64'(out_instr), 64'd0);
      chk("reset_stall", 64'(fetch_stall), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);
      n_rst = 1'b1;
      @(negedge clk);

      // 1: three pushes then three pops in order
      step(1, 32'h100, 0, 0);
      chk("t1_latency_valid", 64'(out_valid), 64'd1);
      chk("t1_latency_pc", 64'(out_pc), 64'h100);
      step(1, 32'h104, 0, 0);
      step(1, 32'h108, 0, 0);
      chk("t1_count3", 64'(count), 64'd3);
      chk("t1_head_pc", 64'(out_pc), 64'h100);
      chk("t1_head_instr", 64'(out_instr), 64'hA5A5_0100);
      chk("t1_head_gb", 64'(out_guesses_branch), 64'd0);
      chk("t1_head_pred", 64'(out_prediction), 64'h140);
      for (int i = 0; i < 3; i++) begin
         chk("t1_pop_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
         step(0, 0, 1, 0);
      end
      chk("t1_empty_valid", 64'(out_valid), 64'd0);
      chk("t1_empty_count", 64'(count), 64'd0);

      // 2: fill to 8, stall at 7, overflow on 9th
      for (int i = 0; i < 8; i++) begin
         step(1, 32'h400 + 32'(4 * i), 0, 0);
         chk("t2_count", 64'(count), 64'(i + 1));
         chk("t2_stall", 64'(fetch_stall), 64'(i + 1 >= 7));
      end
      chk("t2_ovf_before", 64'(overflow), 64'd0);
      step(1, 32'h4FF, 0, 0);
      chk("t2_drop_count", 64'(count), 64'd8);
      chk("t2_ovf_set", 64'(overflow), 64'd1);
      chk("t2_head_kept", 64'(out_pc), 64'h400);
      step(0, 0, 0, 0);
      chk("t2_ovf_sticky", 64'(overflow), 64'd1);

      // 3: push+pop at full
      step(1, 32'h200, 1, 0);
      chk("t3_count_full", 64'(count), 64'd8);
      chk("t3_head_adv", 64'(out_pc), 64'h404);
      for (int i = 0; i < 8; i++) begin
         exp_pc = (i < 7) ? 32'h404 + 32'(4 * i) : 32'h200;
         chk("t3_pop_pc", 64'(out_pc), 64'(exp_pc));
         step(0, 0, 1, 0);
      end
      chk("t3_empty", 64'(count), 64'd0);

      // 4: 12 interleaved pushes/pops across pointer wrap, checked against a queue model
      pushed = 0;
      k = 0;
      while ((pushed < 12 || model_q.size() != 0) && k < 60) begin
         v = (pushed < 12) && (k % 3 != 2);
         r = (k % 2 == 1);
         chk("t4_valid", 64'(out_valid), 64'(model_q.size() != 0));
         chk("t4_count", 64'(count), 64'(model_q.size()));
         if (model_q.size() != 0) chk("t4_pc", 64'(out_pc), 64'(model_q[0]));
         if (r && model_q.size() != 0) void'(model_q.pop_front());
         if (v) begin
            model_q.push_back(32'h500 + 32'(4 * pushed));
            pushed++;
         end
         step(v, 32'h500 + 32'(4 * (v ? pushed - 1 : 0)), r, 0);
         k++;
      end
      chk("t4_bound", 64'(k < 60), 64'd1);
      chk("t4_drained", 64'(count), 64'd0);

      // 5: flush with push and ready in the same cycle
      for (int i = 0; i < 5; i++) step(1, 32'h600 + 32'(4 * i), 0, 0);
      chk("t5_count5", 64'(count), 64'd5);
      step(1, 32'h6FF, 1, 1);
      chk("t5_flush_count", 64'(count), 64'd0);
      chk("t5_flush_valid", 64'(out_valid), 64'd0);
      chk("t5_ovf_survives", 64'(overflow), 64'd1);
      step(1, 32'h300, 0, 0);
      chk("t5_after_pc", 64'(out_pc), 64'h300);
      chk("t5_after_count", 64'(count), 64'd1);

      // 6: asynchronous reset between edges
      for (int i = 0; i < 3; i++) step(1, 32'h700 + 32'(4 * i), 0, 0);
      chk("t6_count4", 64'(count), 64'd4);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t6_async_count", 64'(count), 64'd0);
      chk("t6_async_valid", 64'(out_valid), 64'd0);
      chk("t6_async_ovf", 64'(overflow), 64'd0);
      chk("t6_async_pc", 64'(out_pc), 64'd0);
      #10;
      n_rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction buffer that receives the fetch stage's output, with fields valid, pc, instr, guesses_branch and prediction. It is the receiving end of the fetch output channel and presents buffered instructions in order to decode, one per cycle, under a valid/ready handshake. It decouples fetch from decode stalls and discards all contents on a branch misprediction flush.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2.
PTR_W, $clog2(DEPTH), head/tail pointer width; derived, do not override.

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  asynchronous active-low reset
fetch  input  fetch_out_ifc.in  incoming instruction from fetch (valid, pc, instr, guesses_branch, prediction)
flush  input  1  misprediction flush (branch_fb if_branch && !if_prediction_correct)
decode_ready  input  1  decode accepts the head entry this cycle
out_valid  output  1  head entry present
out_pc  output  `ADDR_WIDTH  head entry pc
out_instr  output  32  head entry instruction word
out_guesses_branch  output  1  head entry predicted-taken flag
out_prediction  output  `ADDR_WIDTH  head entry predicted target
fetch_stall  output  1  fetch must not present a new instruction next cycle
count  output  PTR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky error: an instruction was dropped

Behaviour:
- One clock domain (clk). n_rst is asynchronous and active-low.
- Reset: head=0, tail=0, count=0, overflow=0, all storage=0. Therefore out_valid=0, out_* = 0, fetch_stall=0.
- Storage: circular array of DEPTH entries, each {pc, instr, guesses_branch, prediction}. head and tail wrap modulo DEPTH (natural PTR_W overflow).
- pop = out_valid && decode_ready && !flush.
- push = fetch.valid && !flush && (count < DEPTH || pop).
- Push writes the entry at tail; tail increments.
- Pop increments head.
- count updates as count + push - pop. Simultaneous push and pop leaves count unchanged, including at full and at count==1.
- Output is first-word-fall-through from registered storage:
  - out_valid = (count != 0).
  - out_* = entry[head].
  - When empty, out_* hold the stale entry[head]; consumers ignore them.
- Latency: an instruction pushed in cycle N is visible on out_* in cycle N+1. There is no same-cycle bypass.
- Ordering: strictly FIFO.
- fetch_stall = (count >= DEPTH-1). This gives fetch one cycle of reaction slack; it is a combinational decode of the registered count.
- Overflow: fetch.valid && !flush && count==DEPTH && !pop:
  - the instruction is dropped and state is unchanged;
  - overflow is set to 1 next cycle;
  - overflow is cleared only by reset (flush does not clear it).
- Flush, synchronous:
  - next cycle: head=0, tail=0, count=0;
  - a push or a decode_ready in the same cycle is ignored;
  - storage contents are left as is.
- Asserting n_rst mid-operation clears all state immediately, regardless of clk.
- No X propagation: out_* are always driven from initialized storage.

Test Plan:
1. Reset then 3 pushes (pc 0x100/0x104/0x108) with decode_ready=0 -> count=3, out_valid=1, out_pc=0x100. Raise decode_ready for 3 cycles -> pc 0x100, 0x104, 0x108 in order, then out_valid=0, count=0.
2. DEPTH=8: push 7 with no pops -> fetch_stall rises when count=7. 8th push -> count=8. 9th push with decode_ready=0 -> dropped, count stays 8, overflow=1 next cycle and stays 1.
3. count=8, push pc 0x200 and pop in the same cycle -> count stays 8, head advances, 0x200 emerges last after 7 more pops.
4. 12 pushes interleaved with pops, so pointers wrap past DEPTH -> the output order matches the input order exactly.
5. count=5, assert flush together with fetch.valid and decode_ready -> next cycle count=0, out_valid=0, nothing popped. A following push of pc 0x300 appears at out_pc one cycle later.
6. Drop n_rst asynchronously between clock edges with count=4 -> count=0, out_valid=0, overflow=0 immediately, without waiting for a clk edge.
